// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Also holds the relative-branch offset table used by pc_offset_lut.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef logic [2:0] off_idx_t;

    localparam int unsigned STACK_DEPTH = 4;
    localparam logic [2:0]  SP_FULL     = 3'd4;

    // 8-bit two's complement offsets; callers sign-extend to the PC width.
    function automatic logic [7:0] offset_raw(input off_idx_t idx);
        logic [7:0] val;
        case (idx)
            3'd0:    val = 8'h02;
            3'd1:    val = 8'hF6;
            3'd2:    val = 8'h0A;
            3'd3:    val = 8'hEC;
            3'd4:    val = 8'h14;
            3'd5:    val = 8'hCE;
            3'd6:    val = 8'h32;
            3'd7:    val = 8'hC4;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/pc_offset_lut.sv
// Combinational branch-offset lookup: 3-bit index to a D-bit signed offset.
// D must be wider than 8 bits.
module pc_offset_lut
    import pc_pkg::*;
#(
    parameter int unsigned D = 12
) (
    input  off_idx_t       idx_i,
    output logic [D-1:0]   offset_o
);

    logic [7:0] raw_s;

    // Sign-extend the table entry to the PC width.
    always_comb begin
        raw_s    = offset_raw(idx_i);
        offset_o = {{(D-8){raw_s[7]}}, raw_s};
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with IDLE/RUN/HALTED run control.
// Optional return stack enabled by defining PC_CALL_STACK_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned    D          = 12,
    parameter logic [D-1:0]   START_ADDR = '0
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Start,
    input  logic           Halt_req,
    input  logic           Stall,
    input  logic           Branch_en,
    input  logic           Branch_taken,
    input  logic [2:0]     How_high,
    input  logic           Jump_en,
    input  logic [D-1:0]   Jump_addr,
    output logic [D-1:0]   Prog_ctr,
    output logic           Running,
    output logic           Done
`ifdef PC_CALL_STACK_EN
    ,
    input  logic           Call_en,
    input  logic           Ret_en,
    output logic           Stack_err
`endif
);

    state_t         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic           running_q, running_d;
    logic           done_q, done_d;
    logic [D-1:0]   offset_s;
    logic [D-1:0]   pc_inc_s;

`ifdef PC_CALL_STACK_EN
    logic [D-1:0]   stack_q [STACK_DEPTH];
    logic [D-1:0]   stack_d [STACK_DEPTH];
    logic [2:0]     sp_q, sp_d;
    logic           stack_err_q, stack_err_d;
    logic [1:0]     top_idx_s;

    assign top_idx_s = sp_q[1:0] - 2'd1;
    assign Stack_err = stack_err_q;
`endif

    pc_offset_lut #(.D(D)) u_offset_lut (
        .idx_i    (How_high),
        .offset_o (offset_s)
    );

    assign pc_inc_s = pc_q + D'(1);
    assign Prog_ctr = pc_q;
    assign Running  = running_q;
    assign Done     = done_q;

    // State, PC and status registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= START_ADDR;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef PC_CALL_STACK_EN
            sp_q        <= 3'd0;
            stack_err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef PC_CALL_STACK_EN
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
`endif
        end
    end

    // Next-state logic; Start is ignored while already running.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start)    state_d = RUN;    else state_d = IDLE;
            RUN:     if (Halt_req) state_d = HALTED; else state_d = RUN;
            HALTED:  if (Start)    state_d = RUN;    else state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // PC update and status outputs; halt outranks every other control.
    always_comb begin
        pc_d      = pc_q;
`ifdef PC_CALL_STACK_EN
        sp_d        = sp_q;
        stack_err_d = stack_err_q;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_d[i] = stack_q[i];
        end
`endif
        case (state_q)
            IDLE, HALTED: begin
                if (Start) begin
                    pc_d = START_ADDR;
`ifdef PC_CALL_STACK_EN
                    sp_d = 3'd0;
`endif
                end else begin
                    pc_d = pc_q;
                end
            end
            RUN: begin
                if (Halt_req || Stall) begin
                    pc_d = pc_q;
                end else if (Jump_en) begin
                    pc_d = Jump_addr;
`ifdef PC_CALL_STACK_EN
                end else if (Call_en) begin
                    if (sp_q == SP_FULL) begin
                        stack_err_d = 1'b1;
                        pc_d        = pc_inc_s;
                    end else begin
                        stack_d[sp_q[1:0]] = pc_inc_s;
                        sp_d               = sp_q + 3'd1;
                        pc_d               = Jump_addr;
                    end
                end else if (Ret_en) begin
                    if (sp_q == 3'd0) begin
                        stack_err_d = 1'b1;
                        pc_d        = pc_inc_s;
                    end else begin
                        pc_d = stack_q[top_idx_s];
                        sp_d = sp_q - 3'd1;
                    end
`endif
                end else if (Branch_en && Branch_taken) begin
                    pc_d = pc_q + offset_s;
                end else begin
                    pc_d = pc_inc_s;
                end
            end
            default: pc_d = START_ADDR;
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == HALTED);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver queues expectations, monitor compares.
module tb_pc_sequencer;

    typedef struct {
        logic [11:0] pc;
        logic        run;
        logic        done;
        logic        err;
        string       nm;
    } exp_t;

    logic        Clk, Reset_n, Start, Halt_req, Stall, Branch_en, Branch_taken, Jump_en;
    logic [2:0]  How_high;
    logic [11:0] Jump_addr, Prog_ctr;
    logic        Running, Done;
    logic        Call_en, Ret_en, Stack_err;

    exp_t  q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    event  sample_ev;

    pc_sequencer #(.D(12), .START_ADDR(12'h000)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Halt_req     (Halt_req),
        .Stall        (Stall),
        .Branch_en    (Branch_en),
        .Branch_taken (Branch_taken),
        .How_high     (How_high),
        .Jump_en      (Jump_en),
        .Jump_addr    (Jump_addr),
        .Prog_ctr     (Prog_ctr),
        .Running      (Running),
        .Done         (Done)
`ifdef PC_CALL_STACK_EN
        ,
        .Call_en      (Call_en),
        .Ret_en       (Ret_en),
        .Stack_err    (Stack_err)
`endif
    );

`ifndef PC_CALL_STACK_EN
    assign Stack_err = 1'b0;
`endif

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Monitor: compare outputs against the oldest pending expectation.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(negedge Clk or sample_ev);
            if (q.size() > 0) begin
                e   = q.pop_front();
                n_cmp++;
                bad = (Prog_ctr !== e.pc) || (Running !== e.run) || (Done !== e.done);
`ifdef PC_CALL_STACK_EN
                bad = bad || (Stack_err !== e.err);
`endif
                if (bad) begin
                    n_bad++;
                    $display("FAIL %s: got pc=%h run=%b done=%b err=%b, want pc=%h run=%b done=%b err=%b",
                             e.nm, Prog_ctr, Running, Done, Stack_err, e.pc, e.run, e.done, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        Start = 1'b0; Halt_req = 1'b0; Stall = 1'b0; Branch_en = 1'b0;
        Branch_taken = 1'b0; How_high = 3'd0; Jump_en = 1'b0; Jump_addr = 12'h000;
        Call_en = 1'b0; Ret_en = 1'b0;
    endtask

    task automatic expect_now(input logic [11:0] p, input logic r, input logic d,
                              input logic e, input string nm);
        exp_t x;
        x.pc = p; x.run = r; x.done = d; x.err = e; x.nm = nm;
        q.push_back(x);
    endtask

    task automatic cyc(input logic [11:0] p, input logic r, input logic d,
                       input logic e, input string nm);
        @(posedge Clk);
        expect_now(p, r, d, e, nm);
        @(negedge Clk);
    endtask

    task automatic branch(input logic [2:0] idx, input logic [11:0] p, input string nm);
        clr(); Branch_en = 1'b1; Branch_taken = 1'b1; How_high = idx;
        cyc(p, 1'b1, 1'b0, 1'b0, nm);
    endtask

    task automatic jump(input logic [11:0] a);
        clr(); Jump_en = 1'b1; Jump_addr = a;
        cyc(a, 1'b1, 1'b0, 1'b0, "jump");
    endtask

    initial begin
        Reset_n = 1'b1;
        clr();
        #1 Reset_n = 1'b0;
        #2 expect_now(12'h000, 1'b0, 1'b0, 1'b0, "reset_state");
        -> sample_ev;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        Jump_en = 1'b1; Jump_addr = 12'h100;
        cyc(12'h000, 1'b0, 1'b0, 1'b0, "idle_ignores_jump");
        clr(); Start = 1'b1;
        cyc(12'h000, 1'b1, 1'b0, 1'b0, "start");
        clr();
        for (int i = 1; i <= 5; i++) cyc(12'(i), 1'b1, 1'b0, 1'b0, "increment");

        jump(12'd30);
        branch(3'd3, 12'd10, "branch_minus20");
        branch(3'd6, 12'd60, "branch_plus50");
        clr(); Branch_en = 1'b1; Branch_taken = 1'b0; How_high = 3'd6;
        cyc(12'd61, 1'b1, 1'b0, 1'b0, "branch_not_taken");

        jump(12'd5);
        branch(3'd1, 12'hFFB, "wrap_down");
        jump(12'hFFF);
        clr();
        cyc(12'h000, 1'b1, 1'b0, 1'b0, "wrap_up");
        branch(3'd0, 12'h002, "branch_plus2");
        branch(3'd7, 12'hFC6, "branch_minus60");
        branch(3'd2, 12'hFD0, "branch_plus10");
        branch(3'd4, 12'hFE4, "branch_plus20");
        branch(3'd5, 12'hFB2, "branch_minus50");

        jump(12'd7);
        clr(); Stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc(12'd7, 1'b1, 1'b0, 1'b0, "stall_hold");
        Jump_en = 1'b1; Jump_addr = 12'h100;
        cyc(12'd7, 1'b1, 1'b0, 1'b0, "stall_over_jump");
        clr();
        cyc(12'd8, 1'b1, 1'b0, 1'b0, "after_stall");
        cyc(12'd9, 1'b1, 1'b0, 1'b0, "after_stall");
        Halt_req = 1'b1; Jump_en = 1'b1; Jump_addr = 12'h100;
        cyc(12'd9, 1'b0, 1'b1, 1'b0, "halt_over_jump");
        clr();
        cyc(12'd9, 1'b0, 1'b1, 1'b0, "done_sticky");
        cyc(12'd9, 1'b0, 1'b1, 1'b0, "done_sticky");
        Jump_en = 1'b1; Jump_addr = 12'h100; Branch_en = 1'b1; Branch_taken = 1'b1;
        cyc(12'd9, 1'b0, 1'b1, 1'b0, "halted_ignores_controls");
        clr(); Start = 1'b1;
        cyc(12'h000, 1'b1, 1'b0, 1'b0, "restart");
        cyc(12'h001, 1'b1, 1'b0, 1'b0, "start_in_run_ignored");

        jump(12'd41);
        clr();
        cyc(12'd42, 1'b1, 1'b0, 1'b0, "reach_42");
        #2 Reset_n = 1'b0;
        #1 expect_now(12'h000, 1'b0, 1'b0, 1'b0, "async_reset_midrun");
        -> sample_ev;
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc(12'h000, 1'b0, 1'b0, 1'b0, "idle_after_reset");
        Start = 1'b1;
        cyc(12'h000, 1'b1, 1'b0, 1'b0, "start_after_reset");
        clr();
        cyc(12'h001, 1'b1, 1'b0, 1'b0, "run_after_reset");

`ifdef PC_CALL_STACK_EN
        Call_en = 1'b1; Jump_addr = 12'h200;
        for (int i = 0; i < 4; i++) cyc(12'h200, 1'b1, 1'b0, 1'b0, "call_push");
        cyc(12'h201, 1'b1, 1'b0, 1'b1, "call_overflow");
        clr(); Ret_en = 1'b1;
        for (int i = 0; i < 3; i++) cyc(12'h201, 1'b1, 1'b0, 1'b1, "ret_pop");
        cyc(12'h002, 1'b1, 1'b0, 1'b1, "ret_pop_first");
        cyc(12'h003, 1'b1, 1'b0, 1'b1, "ret_underflow");
        clr();
`endif

        @(negedge Clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer; consumer end of the 3-bit branch-offset index interface.
- Holds the instruction fetch address and steps it each cycle: by +1, by a relative offset selected by a 3-bit index, or by an absolute jump.
- Sits between the control decoder (supplies index and branch condition) and instruction ROM (consumes Prog_ctr).
- Adds a Start/Done run handshake for the test harness.

Parameters:
- D, 12, PC width in bits; all PC arithmetic is modulo 2^D.
- START_ADDR, 0, PC value loaded on Start.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  begin execution; sampled in IDLE or HALTED.
- Halt_req  input  1  stop after the current instruction.
- Stall  input  1  hold PC this cycle.
- Branch_en  input  1  current instruction is a relative branch.
- Branch_taken  input  1  branch condition true.
- How_high  input  3  offset index into the offset table.
- Jump_en  input  1  absolute jump this cycle.
- Jump_addr  input  D  absolute target.
- Prog_ctr  output  D  current fetch address.
- Running  output  1  high in RUN.
- Done  output  1  high in HALTED, sticky.

Behaviour:
- Reset (Reset_n=0, asynchronous): state=IDLE, Prog_ctr=START_ADDR, Running=0, Done=0.
- States:
  - IDLE: waits for Start. Start=1 -> RUN, Prog_ctr=START_ADDR.
  - RUN: Prog_ctr updates every cycle unless stalled; one-cycle latency, so the value computed at edge N is visible after edge N.
  - HALTED: Prog_ctr frozen, Done=1. Start=1 -> RUN, Prog_ctr=START_ADDR, Done=0.
- RUN update priority (highest first):
  - Halt_req -> HALTED, PC unchanged.
  - Stall -> hold PC.
  - Jump_en -> PC=Jump_addr.
  - Branch_en&Branch_taken -> PC=PC+offset(How_high).
  - Otherwise -> PC=PC+1.
- Branch_en with Branch_taken=0 -> PC+1.
- Offset table (sign-extended to D): 0:+2, 1:-10, 2:+10, 3:-20, 4:+20, 5:-50, 6:+50, 7:-60.
- Addition is two's complement modulo 2^D. No overflow flag; wrap is legal (PC=5, offset -10 -> 2^D-5).
- Start while in RUN is ignored.
- All control inputs other than Start are ignored outside RUN.
- Simultaneous Halt_req and Jump_en: halt wins, jump discarded.
- Asynchronous reset mid-run returns to IDLE immediately; no Done pulse.

Optional Feature:
- Macro PC_CALL_STACK_EN.
- Defined:
  - Adds ports Call_en, Ret_en (inputs, 1 bit each) and Stack_err (output, sticky, reset 0).
  - 4-entry return stack.
  - Call_en (priority just below Jump_en) pushes PC+1 and sets PC=Jump_addr.
  - Ret_en pops into PC.
  - Push when full or pop when empty: Stack_err=1, PC=PC+1, stack unchanged.
  - Stack pointer clears on reset and on Start.
- Undefined: none of these ports or the stack exist; behaviour is exactly as above.

Decomposition:
- Package pc_pkg holds:
  - state enum {IDLE, RUN, HALTED};
  - offset index typedef (logic[2:0]);
  - stack depth constant 4.
- One sub-module, pc_offset_lut: combinational How_high -> D-bit signed offset.
- pc_sequencer holds the FSM, the PC register and the optional stack.

Test Plan:
- Reset, Start pulse, no controls for 5 cycles -> Prog_ctr 0,1,2,3,4,5; Running=1.
- At PC=30: Branch_en=1, Branch_taken=1, How_high=3 -> PC=10. Then How_high=6 -> PC=60. At PC=60 with Branch_taken=0 -> PC=61.
- At PC=5: How_high=1 (-10) -> PC=0xFFB (D=12). From PC=0xFFF with no controls -> PC=0x000.
- Stall held 3 cycles at PC=7 -> PC stays 7. Stall and Jump_en (Jump_addr=0x100) together -> PC stays 7.
- Halt_req with Jump_en at PC=9 -> HALTED, PC=9, Done=1 held. Next Start -> PC=0, Done=0.
- Reset_n low mid-run at PC=42 -> immediately PC=0, IDLE, Done=0.
- With PC_CALL_STACK_EN: 5 calls -> the fifth sets Stack_err=1. Then ret from empty stack also sets Stack_err=1.
